// File: rtl/clint_ctrl_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses,
// trap instruction encodings, mcause codes, mstatus bit positions and the
// FSM state encoding, plus mstatus rewrite helpers used on trap entry/exit.
package clint_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        S_MEPC     = 3'd1,
        S_MSTATUS  = 3'd2,
        S_MCAUSE   = 3'd3,
        S_MRET     = 3'd4,
        S_ASSERT   = 3'd5
    } state_t;

    // CSR numbers travel on a 32-bit address bus, upper bits zero.
    function automatic logic [31:0] csr_addr_ext(input logic [11:0] addr);
        return {20'd0, addr};
    endfunction

    // Trap entry: save MIE into MPIE, then disable interrupts.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, then set MPIE.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_ctrl_if.sv
// Execute-stage <-> interrupt controller bundle.
// master: execute stage / CSR file side; slave: the controller.
// No handshake: the controller answers with clint_busy_o as a hold request.
interface clint_ctrl_if;

    logic [31:0] ins_i;
    logic [31:0] ins_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        div_req_i;
    logic        div_busy_i;
    logic        ext_int_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;

    logic        csr_wr_en_o;
    logic [31:0] csr_wr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic        clint_busy_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    modport master (
        output ins_i, ins_addr_i, jump_flag_i, jump_addr_i,
        output div_req_i, div_busy_i, ext_int_i,
        output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        input  csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o,
        input  clint_busy_o, int_assert_o, int_addr_o
    );

    modport slave (
        input  ins_i, ins_addr_i, jump_flag_i, jump_addr_i,
        input  div_req_i, div_busy_i, ext_int_i,
        input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
        output csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o,
        output clint_busy_o, int_assert_o, int_addr_o
    );

endinterface

// File: rtl/clint_ctrl_sync_ff.sv
// Multi-flop synchronizer for the asynchronous external interrupt level.
// Latency: STAGES clk cycles from d to q.
// No backpressure: free-running shift chain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw level through the flop chain; reset clears any stale level.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: ecall/ebreak/external irq entry and mret exit.
// Latency: trap accept -> int_assert_o 4 cycles; mret accept -> 2 cycles.
// Backpressure: raises clint_busy_o from the accept cycle until S_ASSERT ends.
module clint_ctrl
    import clint_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES          = 2,
    parameter logic [31:0] RESET_MTVEC_FALLBACK = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    clint_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic        ret_q, ret_d;

    logic        ext_int_sync;
    logic        is_ecall, is_ebreak, is_mret, irq_ok;
    logic [31:0] trap_target;

    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        int_assert;
    logic [31:0] int_addr;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ext_int_i),
        .q   (ext_int_sync)
    );

    assign is_ecall  = (bus.ins_i == INST_ECALL);
    assign is_ebreak = (bus.ins_i == INST_EBREAK);
    assign is_mret   = (bus.ins_i == INST_MRET);

    // An interrupt is only taken with the divider quiet, so an in-flight
    // divide never straddles the redirect; the level must simply persist.
    assign irq_ok = ext_int_sync & bus.csr_mstatus_i[MSTATUS_MIE]
                  & ~bus.div_req_i & ~bus.div_busy_i;

    // Vectored mode bits are dropped; an unprogrammed mtvec falls back.
    assign trap_target = (bus.csr_mtvec_i == 32'd0) ? RESET_MTVEC_FALLBACK
                                                    : {bus.csr_mtvec_i[31:2], 2'b00};

    // State and trap-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
            ret_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            ret_q   <= ret_d;
        end
    end

    // Event accept in IDLE, then one CSR write per state and a redirect strobe.
    always_comb begin
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        ret_d      = ret_q;
        wr_en      = 1'b0;
        wr_addr    = 32'd0;
        wr_data    = 32'd0;
        busy       = 1'b0;
        int_assert = 1'b0;
        int_addr   = 32'd0;

        case (state_q)
            IDLE: begin
                if (is_ecall || is_ebreak) begin
                    busy    = 1'b1;
                    state_d = S_MEPC;
                    epc_d   = bus.ins_addr_i;
                    cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    ret_d   = 1'b0;
                end else if (is_mret) begin
                    busy    = 1'b1;
                    state_d = S_MRET;
                    ret_d   = 1'b1;
                end else if (irq_ok) begin
                    // The execute instruction retires, so resume after it
                    // unless it is redirecting.
                    busy    = 1'b1;
                    state_d = S_MEPC;
                    epc_d   = bus.jump_flag_i ? bus.jump_addr_i
                                              : bus.ins_addr_i + 32'd4;
                    cause_d = CAUSE_EXT_INT;
                    ret_d   = 1'b0;
                end
            end
            S_MEPC: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = csr_addr_ext(CSR_MEPC);
                wr_data = epc_q;
                state_d = S_MSTATUS;
            end
            S_MSTATUS: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = csr_addr_ext(CSR_MSTATUS);
                wr_data = mstatus_on_trap(bus.csr_mstatus_i);
                state_d = S_MCAUSE;
            end
            S_MCAUSE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = csr_addr_ext(CSR_MCAUSE);
                wr_data = cause_q;
                state_d = S_ASSERT;
            end
            S_MRET: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = csr_addr_ext(CSR_MSTATUS);
                wr_data = mstatus_on_mret(bus.csr_mstatus_i);
                state_d = S_ASSERT;
            end
            S_ASSERT: begin
                busy       = 1'b1;
                int_assert = 1'b1;
                int_addr   = ret_q ? bus.csr_mepc_i : trap_target;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs stay quiet while reset is held, even mid-sequence.
        if (rst) begin
            wr_en      = 1'b0;
            wr_addr    = 32'd0;
            wr_data    = 32'd0;
            busy       = 1'b0;
            int_assert = 1'b0;
            int_addr   = 32'd0;
        end
    end

    assign bus.csr_wr_en_o   = wr_en;
    assign bus.csr_wr_addr_o = wr_addr;
    assign bus.csr_wr_data_o = wr_data;
    assign bus.clint_busy_o  = busy;
    assign bus.int_assert_o  = int_assert;
    assign bus.int_addr_o    = int_addr;

endmodule

// File: tb/tb_clint_ctrl.sv
// Scoreboard bench for clint_ctrl: expected CSR writes / redirects are queued
// when an event is accepted and compared as the controller emits them.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_clint_ctrl;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] MRET     = 32'h3020_0073;
    localparam logic [31:0] FALLBACK = 32'h0000_0080;

    typedef struct {
        bit          is_assert;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   w;

    clint_ctrl_if bus ();

    clint_ctrl #(
        .SYNC_STAGES          (2),
        .RESET_MTVEC_FALLBACK (FALLBACK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_assert = 1'b0; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_as(input logic [31:0] a);
        exp_t e;
        e.is_assert = 1'b1; e.addr = a; e.data = 32'd0;
        sb.push_back(e);
    endtask

    task automatic push_trap(input logic [31:0] epc, input logic [31:0] ms,
                             input logic [31:0] cause, input logic [31:0] tgt);
        push_wr(32'h341, epc);
        push_wr(32'h300, ms);
        push_wr(32'h342, cause);
        push_as(tgt);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.csr_wr_en_o || bus.int_assert_o)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", {30'd0, bus.csr_wr_en_o, bus.int_assert_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (e.is_assert) begin
                    check_eq("int_assert", {31'd0, bus.int_assert_o}, 32'd1);
                    check_eq("int_addr", bus.int_addr_o, e.addr);
                end else begin
                    check_eq("csr_wr_en", {31'd0, bus.csr_wr_en_o}, 32'd1);
                    check_eq("csr_wr_addr", bus.csr_wr_addr_o, e.addr);
                    check_eq("csr_wr_data", bus.csr_wr_data_o, e.data);
                end
            end
        end
    end

    // Returns at the negedge of the accept cycle (or after the budget).
    task automatic wait_busy(input int max_cyc, output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.clint_busy_o && waited < max_cyc) begin
            @(posedge clk); #1;
            waited++;
            @(negedge clk);
        end
        check_eq("accept_busy", {31'd0, bus.clint_busy_o}, 32'd1);
    endtask

    // After accept: withdraw the event, expect n_more busy cycles, then idle.
    task automatic finish_seq(input int n_more);
        for (int i = 0; i < n_more; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                bus.ins_i       = NOP;
                bus.ext_int_i   = 1'b0;
                bus.jump_flag_i = 1'b0;
            end
            @(negedge clk);
            check_eq("busy_in_seq", {31'd0, bus.clint_busy_o}, 32'd1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("idle_after_seq", {31'd0, bus.clint_busy_o}, 32'd0);
        check_eq("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_wr_en"}, {31'd0, bus.csr_wr_en_o}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, bus.clint_busy_o}, 32'd0);
        check_eq({tag, "_assert"}, {31'd0, bus.int_assert_o}, 32'd0);
        check_eq({tag, "_outs"}, bus.csr_wr_addr_o | bus.csr_wr_data_o | bus.int_addr_o, 32'd0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq(tag, {31'd0, bus.clint_busy_o}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        bus.ins_i         = ECALL;
        bus.ins_addr_i    = 32'h0;
        bus.jump_flag_i   = 1'b0;
        bus.jump_addr_i   = 32'h0;
        bus.div_req_i     = 1'b0;
        bus.div_busy_i    = 1'b0;
        bus.ext_int_i     = 1'b1;
        bus.csr_mtvec_i   = 32'h400;
        bus.csr_mepc_i    = 32'h0;
        bus.csr_mstatus_i = 32'h8;

        // Reset state: outputs silent even with events on the inputs.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        bus.ins_i     = NOP;
        bus.ext_int_i = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        @(posedge clk); #1;

        // ecall: three writes then redirect to mtvec.
        bus.csr_mstatus_i = 32'h8;
        bus.csr_mtvec_i   = 32'h400;
        bus.ins_addr_i    = 32'h100;
        bus.ins_i         = ECALL;
        wait_busy(1, w);
        push_trap(32'h100, 32'h80, 32'd11, 32'h400);
        finish_seq(4);

        // ebreak with mode bits in mtvec, MPIE already set.
        @(posedge clk); #1;
        bus.csr_mstatus_i = 32'h88;
        bus.csr_mtvec_i   = 32'h403;
        bus.ins_addr_i    = 32'h180;
        bus.ins_i         = EBREAK;
        wait_busy(1, w);
        push_trap(32'h180, 32'h80, 32'd3, 32'h400);
        finish_seq(4);

        // ebreak with mtvec unprogrammed: fallback target.
        @(posedge clk); #1;
        bus.csr_mstatus_i = 32'h0;
        bus.csr_mtvec_i   = 32'h0;
        bus.ins_addr_i    = 32'h1c0;
        bus.ins_i         = EBREAK;
        wait_busy(1, w);
        push_trap(32'h1c0, 32'h0, 32'd3, FALLBACK);
        finish_seq(4);

        // mret: restore MIE, redirect to mepc.
        @(posedge clk); #1;
        bus.csr_mtvec_i   = 32'h400;
        bus.csr_mstatus_i = 32'h80;
        bus.csr_mepc_i    = 32'h104;
        bus.ins_i         = MRET;
        wait_busy(1, w);
        push_wr(32'h300, 32'h88);
        push_as(32'h104);
        finish_seq(2);

        // External interrupt through the synchronizer.
        @(posedge clk); #1;
        bus.csr_mstatus_i = 32'h8;
        bus.ins_addr_i    = 32'h200;
        bus.ext_int_i     = 1'b1;
        wait_busy(10, w);
        check_eq("sync_latency", w, 32'd2);
        push_trap(32'h204, 32'h80, 32'h8000_000B, 32'h400);
        finish_seq(4);

        // Interrupt deferred while the divider is requested / busy.
        @(posedge clk); #1;
        bus.ext_int_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.div_req_i  = (i < 3);
            bus.div_busy_i = (i >= 3);
            @(negedge clk);
            check_eq("div_defer_busy", {31'd0, bus.clint_busy_o}, 32'd0);
            @(posedge clk); #1;
        end
        bus.div_busy_i = 1'b0;
        wait_busy(1, w);
        check_eq("div_release_lat", w, 32'd0);
        push_trap(32'h204, 32'h80, 32'h8000_000B, 32'h400);
        finish_seq(4);

        // MIE clear: interrupt never taken.
        @(posedge clk); #1;
        bus.csr_mstatus_i = 32'h0;
        bus.ext_int_i     = 1'b1;
        idle_cycles(10, "mie_off_busy");
        bus.ext_int_i = 1'b0;
        idle_cycles(3, "irq_drop_busy");

        // Interrupt during a redirect: mepc takes the jump target.
        bus.csr_mstatus_i = 32'h8;
        bus.ins_addr_i    = 32'h250;
        bus.jump_flag_i   = 1'b1;
        bus.jump_addr_i   = 32'h300;
        bus.ext_int_i     = 1'b1;
        wait_busy(10, w);
        push_trap(32'h300, 32'h80, 32'h8000_000B, 32'h400);
        finish_seq(4);

        // ecall and a pending interrupt in the same cycle: ecall wins.
        @(posedge clk); #1;
        bus.csr_mstatus_i = 32'h0;
        bus.ext_int_i     = 1'b1;
        idle_cycles(3, "prime_busy");
        bus.csr_mstatus_i = 32'h8;
        bus.ins_addr_i    = 32'h120;
        bus.ins_i         = ECALL;
        wait_busy(1, w);
        push_trap(32'h120, 32'h80, 32'd11, 32'h400);
        finish_seq(4);

        // Reset during S_MSTATUS aborts the sequence.
        @(posedge clk); #1;
        bus.ins_addr_i = 32'h130;
        bus.ins_i      = ECALL;
        wait_busy(1, w);
        push_wr(32'h341, 32'h130);
        @(posedge clk); #1;
        bus.ins_i = NOP;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_rst");
        check_eq("rst_sb_drained", sb.size(), 32'd0);

        // Fresh ecall after the abort runs to completion.
        @(posedge clk); #1;
        bus.ins_addr_i = 32'h140;
        bus.ins_i      = ECALL;
        wait_busy(1, w);
        push_trap(32'h140, 32'h80, 32'd11, 32'h400);
        finish_seq(4);

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("final_sb", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
